demux1x2_stream: RTL and testbench



---
 rtl/demux1x2_pkg.sv | 24 ++
 rtl/demux_chan_buf.sv | 64 ++++++
 rtl/demux1x2_stream.sv | 93 +++++++++
 tb/tb_demux1x2_stream.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/demux1x2_pkg.sv
// Shared definitions for the two-way streaming demultiplexer: buffer depth,
// occupancy encoding and the occupancy update helper.
package demux1x2_pkg;

  localparam int DEPTH = 2;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_FULL  = occ_t'(DEPTH);

  // Push and pop together leave the count unchanged.
  function automatic occ_t next_occ(input occ_t occ, input logic push, input logic pop);
    occ_t nxt;
    case ({push, pop})
      2'b10:   nxt = occ + 2'd1;
      2'b01:   nxt = occ - 2'd1;
      default: nxt = occ;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/demux_chan_buf.sv
// One output channel of the demultiplexer: a 2-entry FIFO whose head word
// drives the channel output and whose valid flag means "non-empty".
module demux_chan_buf
  import demux1x2_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] head,
  output occ_t         occ
);

  logic [W-1:0] head_r;
  logic [W-1:0] tail_r;
  occ_t         occ_r;
  logic         push_ok_s;
  logic         pop_s;

  assign valid     = (occ_r != OCC_EMPTY);
  assign head      = head_r;
  assign occ       = occ_r;
  assign pop_s     = valid && ready;
  assign push_ok_s = push && (occ_r != OCC_FULL);

  // Storage and occupancy; head_r keeps its last word once the buffer drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r <= '0;
      tail_r <= '0;
      occ_r  <= OCC_EMPTY;
    end else begin
      occ_r <= next_occ(occ_r, push_ok_s, pop_s);
      case ({push_ok_s, pop_s})
        2'b10: begin
          if (occ_r == OCC_EMPTY) begin
            head_r <= din;
          end else begin
            tail_r <= din;
          end
        end
        2'b01: begin
          if (occ_r == OCC_FULL) begin
            head_r <= tail_r;
          end else begin
            head_r <= head_r;
          end
        end
        2'b11: begin
          head_r <= din;
        end
        default: begin
          head_r <= head_r;
          tail_r <= tail_r;
        end
      endcase
    end
  end

endmodule

// File: rtl/demux1x2_stream.sv
// Two-way streaming demultiplexer: routes each accepted word to channel 0 or 1
// by its select bit. Define DEMUX1X2_STATS_EN to add per-channel delivery counters.
module demux1x2_stream
  import demux1x2_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  a,
  input  logic          s,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  y0,
  output logic          y0_valid,
  input  logic          y0_ready,
  output logic [W-1:0]  y1,
  output logic          y1_valid,
  input  logic          y1_ready
`ifdef DEMUX1X2_STATS_EN
  ,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
`endif
);

  if (CW < 1) begin : g_cw_bad
    $error("demux1x2_stream: CW must be at least 1");
  end

  occ_t occ0;
  occ_t occ1;
  logic push0_s;
  logic push1_s;

  // Acceptance depends only on the selected channel's registered occupancy.
  always_comb begin
    in_ready = 1'b0;
    if (s) begin
      in_ready = (occ1 != OCC_FULL);
    end else begin
      in_ready = (occ0 != OCC_FULL);
    end
  end

  assign push0_s = in_valid && in_ready && !s;
  assign push1_s = in_valid && in_ready &&  s;

  demux_chan_buf #(.W(W)) u_chan0 (
    .clk   (clk),
    .rst   (rst),
    .push  (push0_s),
    .din   (a),
    .ready (y0_ready),
    .valid (y0_valid),
    .head  (y0),
    .occ   (occ0)
  );

  demux_chan_buf #(.W(W)) u_chan1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push1_s),
    .din   (a),
    .ready (y1_ready),
    .valid (y1_valid),
    .head  (y1),
    .occ   (occ1)
  );

`ifdef DEMUX1X2_STATS_EN
  // Delivered-word counters, wrapping, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (y0_valid && y0_ready) begin
        cnt0 <= cnt0 + CW'(1);
      end else begin
        cnt0 <= cnt0;
      end
      if (y1_valid && y1_ready) begin
        cnt1 <= cnt1 + CW'(1);
      end else begin
        cnt1 <= cnt1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_demux1x2_stream.sv
// Self-checking bench for demux1x2_stream: a directed vector table plus
// hand-written sequences for counters and asynchronous mid-stream reset.
module tb_demux1x2_stream;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic       s;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] y0;
  logic       y0_valid;
  logic       y0_ready;
  logic [7:0] y1;
  logic       y1_valid;
  logic       y1_ready;
`ifdef DEMUX1X2_STATS_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  int errors = 0;
  int checks = 0;

  demux1x2_stream #(.W(8), .CW(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .s        (s),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y0       (y0),
    .y0_valid (y0_valid),
    .y0_ready (y0_ready),
    .y1       (y1),
    .y1_valid (y1_valid),
    .y1_ready (y1_ready)
`ifdef DEMUX1X2_STATS_EN
    ,
    .cnt0     (cnt0),
    .cnt1     (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic       s;
    logic       iv;
    logic       r0;
    logic       r1;
    logic       e_ir;
    logic       e_v0;
    logic [7:0] e_y0;
    logic       e_v1;
    logic [7:0] e_y1;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] da, input logic ds, input logic div,
                       input logic dr0, input logic dr1);
    a        = da;
    s        = ds;
    in_valid = div;
    y0_ready = dr0;
    y1_ready = dr1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    //          a     s     iv    r0    r1    ir    v0    y0     v1    y1
    vecs[0]  = '{8'hA5,1'b0,1'b1,1'b1,1'b1, 1'b1, 1'b1,8'hA5, 1'b0,8'h00};
    vecs[1]  = '{8'h3C,1'b1,1'b1,1'b1,1'b1, 1'b1, 1'b0,8'hA5, 1'b1,8'h3C};
    vecs[2]  = '{8'h00,1'b0,1'b0,1'b1,1'b1, 1'b1, 1'b0,8'hA5, 1'b0,8'h3C};
    vecs[3]  = '{8'h11,1'b0,1'b1,1'b0,1'b1, 1'b1, 1'b1,8'h11, 1'b0,8'h3C};
    vecs[4]  = '{8'h22,1'b0,1'b1,1'b0,1'b1, 1'b1, 1'b1,8'h11, 1'b0,8'h3C};
    vecs[5]  = '{8'h33,1'b0,1'b1,1'b0,1'b1, 1'b0, 1'b1,8'h11, 1'b0,8'h3C};
    vecs[6]  = '{8'h44,1'b1,1'b1,1'b0,1'b0, 1'b1, 1'b1,8'h11, 1'b1,8'h44};
    vecs[7]  = '{8'h55,1'b1,1'b1,1'b0,1'b0, 1'b1, 1'b1,8'h11, 1'b1,8'h44};
    vecs[8]  = '{8'h66,1'b1,1'b1,1'b0,1'b0, 1'b0, 1'b1,8'h11, 1'b1,8'h44};
    vecs[9]  = '{8'h00,1'b0,1'b0,1'b0,1'b1, 1'b0, 1'b1,8'h11, 1'b1,8'h55};
    vecs[10] = '{8'h00,1'b1,1'b0,1'b0,1'b1, 1'b1, 1'b1,8'h11, 1'b0,8'h55};
    vecs[11] = '{8'h33,1'b0,1'b1,1'b1,1'b0, 1'b0, 1'b1,8'h22, 1'b0,8'h55};
    vecs[12] = '{8'h33,1'b0,1'b1,1'b1,1'b0, 1'b1, 1'b1,8'h33, 1'b0,8'h55};
    vecs[13] = '{8'h00,1'b0,1'b0,1'b1,1'b0, 1'b1, 1'b0,8'h33, 1'b0,8'h55};
    vecs[14] = '{8'h66,1'b0,1'b1,1'b0,1'b0, 1'b1, 1'b1,8'h66, 1'b0,8'h55};
    vecs[15] = '{8'h77,1'b0,1'b1,1'b1,1'b0, 1'b1, 1'b1,8'h77, 1'b0,8'h55};
    vecs[16] = '{8'h00,1'b0,1'b0,1'b0,1'b0, 1'b1, 1'b1,8'h77, 1'b0,8'h55};
    vecs[17] = '{8'h88,1'b0,1'b1,1'b0,1'b0, 1'b1, 1'b1,8'h77, 1'b0,8'h55};
    vecs[18] = '{8'h99,1'b0,1'b1,1'b0,1'b0, 1'b0, 1'b1,8'h77, 1'b0,8'h55};
    vecs[19] = '{8'h00,1'b0,1'b0,1'b1,1'b0, 1'b0, 1'b1,8'h88, 1'b0,8'h55};
    vecs[20] = '{8'h00,1'b0,1'b0,1'b1,1'b0, 1'b1, 1'b0,8'h88, 1'b0,8'h55};

    // Reset state while rst is held
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_y0_valid", {31'd0, y0_valid}, 32'd0);
    chk("rst_y1_valid", {31'd0, y1_valid}, 32'd0);
    chk("rst_y0", {24'd0, y0}, 32'd0);
    chk("rst_y1", {24'd0, y1}, 32'd0);
`ifdef DEMUX1X2_STATS_EN
    chk("rst_cnt0", {16'd0, cnt0}, 32'd0);
    chk("rst_cnt1", {16'd0, cnt1}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].s, vecs[i].iv, vecs[i].r0, vecs[i].r1);
      #1;
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_ir});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_y0_valid", i), {31'd0, y0_valid}, {31'd0, vecs[i].e_v0});
      chk($sformatf("v%0d_y0", i), {24'd0, y0}, {24'd0, vecs[i].e_y0});
      chk($sformatf("v%0d_y1_valid", i), {31'd0, y1_valid}, {31'd0, vecs[i].e_v1});
      chk($sformatf("v%0d_y1", i), {24'd0, y1}, {24'd0, vecs[i].e_y1});
    end
`ifdef DEMUX1X2_STATS_EN
    chk("tbl_cnt0", {16'd0, cnt0}, 32'd7);
    chk("tbl_cnt1", {16'd0, cnt1}, 32'd3);
`endif

    // Five channel-1 deliveries from a clean reset
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(8'hC0 + 8'(i), 1'b1, 1'b1, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      chk($sformatf("seq1_y1_%0d", i), {24'd0, y1}, {24'd0, 8'hC0 + 8'(i)});
      @(negedge clk);
    end
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("seq1_y1_valid_drained", {31'd0, y1_valid}, 32'd0);
`ifdef DEMUX1X2_STATS_EN
    chk("seq1_cnt1", {16'd0, cnt1}, 32'd5);
    chk("seq1_cnt0", {16'd0, cnt0}, 32'd0);
`endif

    // Fill channel 0 while stalled, then reset asynchronously mid-cycle
    @(negedge clk);
    drive(8'hD1, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(8'hD2, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(8'hD3, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("seq2_full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("seq2_full_y0", {24'd0, y0}, 32'h000000D1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("seq2_flush_y0_valid", {31'd0, y0_valid}, 32'd0);
    chk("seq2_flush_y1_valid", {31'd0, y1_valid}, 32'd0);
    chk("seq2_flush_y0", {24'd0, y0}, 32'd0);
    chk("seq2_flush_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef DEMUX1X2_STATS_EN
    chk("seq2_flush_cnt0", {16'd0, cnt0}, 32'd0);
    chk("seq2_flush_cnt1", {16'd0, cnt1}, 32'd0);
`endif

    // First push after release is accepted at the next edge
    @(negedge clk);
    rst = 1'b0;
    drive(8'hE7, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("seq3_first_y1_valid", {31'd0, y1_valid}, 32'd1);
    chk("seq3_first_y1", {24'd0, y1}, 32'h000000E7);
    chk("seq3_first_y0_valid", {31'd0, y0_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
